nn_address_generator: RTL and testbench

Address generator for the fully-connected layer datapath. Sits directly downstream of the control unit: consumes its `AG_rst` and `AG_read` strobes and produces the weight-memory and input-memory read addresses, in neuron-major order. It also produces per-neuron framing flags for the ALU/MAC stage. Walks `N_NEURONS × N_INPUTS` address pairs once per layer pass, then raises `done` until restarted.

---
 rtl/nn_pkg.sv | 13 +
 rtl/nn_address_generator.sv | 141 ++++++++++++++
 tb/tb_nn_address_generator.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared types and default layer sizes for the fully-connected layer datapath.
package nn_pkg;

   localparam int unsigned NN_N_INPUTS  = 4;
   localparam int unsigned NN_N_NEURONS = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ag_state_t;

endpackage : nn_pkg

// File: rtl/nn_address_generator.sv
// Neuron-major weight/input address walker for one FC layer pass, with
// per-neuron first/last framing and a sticky done flag.
module nn_address_generator
   import nn_pkg::*;
#(
   parameter int unsigned N_INPUTS  = NN_N_INPUTS,
   parameter int unsigned N_NEURONS = NN_N_NEURONS,
   parameter int unsigned W_ADDR_W  = $clog2(N_INPUTS * N_NEURONS),
   parameter int unsigned X_ADDR_W  = $clog2(N_INPUTS),
   parameter int unsigned N_IDX_W   = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                AG_rst,
   input  logic                AG_read,
   output logic [W_ADDR_W-1:0] w_addr,
   output logic [X_ADDR_W-1:0] x_addr,
   output logic [N_IDX_W-1:0]  neuron_idx,
   output logic                addr_valid,
   output logic                first,
   output logic                last,
   output logic                done
);

   ag_state_t           r_state, w_state_nxt;
   logic [X_ADDR_W-1:0] r_in_cnt, w_in_cnt_nxt;
   logic [N_IDX_W-1:0]  r_n_cnt, w_n_cnt_nxt;
   logic [W_ADDR_W-1:0] r_base, w_base_nxt;

   logic [W_ADDR_W-1:0] r_w_addr, w_w_addr_nxt;
   logic [X_ADDR_W-1:0] r_x_addr, w_x_addr_nxt;
   logic [N_IDX_W-1:0]  r_n_idx, w_n_idx_nxt;
   logic                r_valid, w_valid_nxt;
   logic                r_first, w_first_nxt;
   logic                r_last, w_last_nxt;
   logic                r_done, w_done_nxt;

   logic w_issue;
   logic w_in_last;
   logic w_n_last;

   // A read is honoured only outside DONE and only if no restart wins the cycle.
   assign w_issue   = AG_read && !AG_rst && (r_state != DONE);
   assign w_in_last = (r_in_cnt == X_ADDR_W'(N_INPUTS - 1));
   assign w_n_last  = (r_n_cnt == N_IDX_W'(N_NEURONS - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (AG_rst) begin
         w_state_nxt = IDLE;
      end else if (w_issue) begin
         w_state_nxt = (w_in_last && w_n_last) ? DONE : RUN;
      end
   end

   // Next values of counters and registered outputs.
   always_comb begin
      w_in_cnt_nxt = r_in_cnt;
      w_n_cnt_nxt  = r_n_cnt;
      w_base_nxt   = r_base;
      w_w_addr_nxt = r_w_addr;
      w_x_addr_nxt = r_x_addr;
      w_n_idx_nxt  = r_n_idx;
      w_valid_nxt  = 1'b0;
      w_first_nxt  = 1'b0;
      w_last_nxt   = 1'b0;
      w_done_nxt   = (r_state == DONE);

      if (AG_rst) begin
         w_in_cnt_nxt = '0;
         w_n_cnt_nxt  = '0;
         w_base_nxt   = '0;
         w_w_addr_nxt = '0;
         w_x_addr_nxt = '0;
         w_n_idx_nxt  = '0;
         w_done_nxt   = 1'b0;
      end else if (w_issue) begin
         w_w_addr_nxt = r_base + W_ADDR_W'(r_in_cnt);
         w_x_addr_nxt = r_in_cnt;
         w_n_idx_nxt  = r_n_cnt;
         w_valid_nxt  = 1'b1;
         w_first_nxt  = (r_in_cnt == '0);
         w_last_nxt   = w_in_last;

         if (!w_in_last) begin
            w_in_cnt_nxt = r_in_cnt + X_ADDR_W'(1);
         end else if (w_n_last) begin
            w_in_cnt_nxt = '0;
            w_n_cnt_nxt  = '0;
            w_base_nxt   = '0;
         end else begin
            w_in_cnt_nxt = '0;
            w_n_cnt_nxt  = r_n_cnt + N_IDX_W'(1);
            w_base_nxt   = r_base + W_ADDR_W'(N_INPUTS);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_in_cnt <= '0;
         r_n_cnt  <= '0;
         r_base   <= '0;
         r_w_addr <= '0;
         r_x_addr <= '0;
         r_n_idx  <= '0;
         r_valid  <= 1'b0;
         r_first  <= 1'b0;
         r_last   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_in_cnt <= w_in_cnt_nxt;
         r_n_cnt  <= w_n_cnt_nxt;
         r_base   <= w_base_nxt;
         r_w_addr <= w_w_addr_nxt;
         r_x_addr <= w_x_addr_nxt;
         r_n_idx  <= w_n_idx_nxt;
         r_valid  <= w_valid_nxt;
         r_first  <= w_first_nxt;
         r_last   <= w_last_nxt;
         r_done   <= w_done_nxt;
      end
   end

   assign w_addr     = r_w_addr;
   assign x_addr     = r_x_addr;
   assign neuron_idx = r_n_idx;
   assign addr_valid = r_valid;
   assign first      = r_first;
   assign last       = r_last;
   assign done       = r_done;

endmodule : nn_address_generator

// File: tb/tb_nn_address_generator.sv
// Directed self-checking bench for nn_address_generator: default 4x3 layer
// plus a minimal 2x1 instance.
module tb_nn_address_generator;

   logic clk = 1'b0;
   logic reset;
   logic ag_rst, ag_read;
   logic ag_rst2, ag_read2;

   logic [3:0] w_addr;
   logic [1:0] x_addr;
   logic [1:0] neuron_idx;
   logic       addr_valid, first, last, done;

   logic [0:0] w_addr2;
   logic [0:0] x_addr2;
   logic [0:0] neuron_idx2;
   logic       addr_valid2, first2, last2, done2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   nn_address_generator u_dut (
      .clk        (clk),
      .reset      (reset),
      .AG_rst     (ag_rst),
      .AG_read    (ag_read),
      .w_addr     (w_addr),
      .x_addr     (x_addr),
      .neuron_idx (neuron_idx),
      .addr_valid (addr_valid),
      .first      (first),
      .last       (last),
      .done       (done)
   );

   nn_address_generator #(.N_INPUTS(2), .N_NEURONS(1)) u_dut2 (
      .clk        (clk),
      .reset      (reset),
      .AG_rst     (ag_rst2),
      .AG_read    (ag_read2),
      .w_addr     (w_addr2),
      .x_addr     (x_addr2),
      .neuron_idx (neuron_idx2),
      .addr_valid (addr_valid2),
      .first      (first2),
      .last       (last2),
      .done       (done2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Outputs are inspected 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_pair(input string tag, input int wa, input int xa, input int ni,
                           input logic v, input logic f, input logic l, input logic d);
      chk({tag, ".w_addr"},     32'(w_addr),     32'(wa));
      chk({tag, ".x_addr"},     32'(x_addr),     32'(xa));
      chk({tag, ".neuron_idx"}, 32'(neuron_idx), 32'(ni));
      chk({tag, ".valid"},      32'(addr_valid), 32'(v));
      chk({tag, ".first"},      32'(first),      32'(f));
      chk({tag, ".last"},       32'(last),       32'(l));
      chk({tag, ".done"},       32'(done),       32'(d));
   endtask

   initial begin
      reset = 1'b1; ag_rst = 1'b0; ag_read = 1'b0; ag_rst2 = 1'b0; ag_read2 = 1'b0;
      step();
      step();
      chk_pair("reset", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

      // Continuous pass
      ag_read = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         chk_pair($sformatf("cont%0d", i), i, i % 4, i / 4, 1'b1, (i % 4) == 0, (i % 4) == 3, 1'b0);
      end
      // DONE with AG_read held: ignored for 3 cycles
      for (int i = 0; i < 3; i++) begin
         step();
         chk_pair($sformatf("done_hold%0d", i), 11, 3, 2, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      ag_read = 1'b0; ag_rst = 1'b1;
      step();
      chk_pair("restart1", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      ag_rst = 1'b0;

      // Alternating reads
      for (int i = 0; i < 12; i++) begin
         ag_read = 1'b1;
         step();
         chk_pair($sformatf("pulse%0d", i), i, i % 4, i / 4, 1'b1, (i % 4) == 0, (i % 4) == 3, 1'b0);
         ag_read = 1'b0;
         step();
         chk_pair($sformatf("gap%0d", i), i, i % 4, i / 4, 1'b0, 1'b0, 1'b0, i == 11);
      end
      ag_rst = 1'b1;
      step();
      ag_rst = 1'b0;
      chk_pair("restart2", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // AG_rst wins over a simultaneous AG_read at w_addr=5
      ag_read = 1'b1;
      for (int i = 0; i < 6; i++) step();
      chk_pair("pre_rst5", 5, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
      ag_rst = 1'b1;
      step();
      chk_pair("rst_read", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      ag_rst = 1'b0;
      step();
      chk_pair("after_rst", 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
      ag_read = 1'b0;
      ag_rst = 1'b1;
      step();
      ag_rst = 1'b0;

      // Async reset mid-cycle at w_addr=6
      ag_read = 1'b1;
      for (int i = 0; i < 7; i++) step();
      chk_pair("pre_async6", 6, 2, 1, 1'b1, 1'b0, 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1;
      chk_pair("async", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      reset = 1'b0;
      step();
      chk_pair("post_async0", 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      chk_pair("post_async1", 1, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      ag_read = 1'b0;

      // Minimal 2x1 layer
      ag_read2 = 1'b1;
      step();
      chk("small0.w", 32'(w_addr2), 32'd0);
      chk("small0.x", 32'(x_addr2), 32'd0);
      chk("small0.v", 32'(addr_valid2), 32'd1);
      chk("small0.f", 32'(first2), 32'd1);
      chk("small0.l", 32'(last2), 32'd0);
      step();
      chk("small1.w", 32'(w_addr2), 32'd1);
      chk("small1.x", 32'(x_addr2), 32'd1);
      chk("small1.n", 32'(neuron_idx2), 32'd0);
      chk("small1.v", 32'(addr_valid2), 32'd1);
      chk("small1.f", 32'(first2), 32'd0);
      chk("small1.l", 32'(last2), 32'd1);
      chk("small1.d", 32'(done2), 32'd0);
      step();
      chk("small2.v", 32'(addr_valid2), 32'd0);
      chk("small2.d", 32'(done2), 32'd1);
      ag_read2 = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_nn_address_generator
